ipm_distributed_shiftregister_mc_v2_0: RTL and testbench

IPM_DISTRIBUTED_SHIFTREGISTER_MC_V2_0 -- requirements
Module: ipm_distributed_shiftregister_mc_v2_0

---
 rtl/ipm_distributed_shiftregister_mc_v2_0_pkg.sv | 30 +++
 rtl/ipm_distributed_shiftregister_mc_v2_0_ram.sv | 31 +++
 rtl/ipm_distributed_shiftregister_mc_v2_0.sv | 117 +++++++++++
 tb/tb_ipm_distributed_shiftregister_mc_v2_0.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ipm_distributed_shiftregister_mc_v2_0_pkg.sv
// Shared definitions for the distributed shift-register family.
//   MAX_DEPTH_LIMIT  : largest supported latency
//   fill_state_t     : FILL / RUN encodings of the fill FSM
//   calc_addr_width  : buffer address width for a given MAX_DEPTH
package ipm_shiftregister_pkg;

   localparam int MAX_DEPTH_LIMIT = 1024;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } fill_state_t;

   // 4 bits for shallow buffers so small configurations share one RAM shape;
   // otherwise ceil(log2(max_depth)), never above log2(MAX_DEPTH_LIMIT).
   function automatic int calc_addr_width(input int max_depth);
      int w;
      if (max_depth <= 16) begin
         return 4;
      end
      w = 0;
      for (int i = 0; i < 10; i++) begin
         if ((1 << i) < max_depth) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/ipm_distributed_shiftregister_mc_v2_0_ram.sv
// Circular buffer storage: synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// Contents are intentionally not reset.
module ipm_distributed_ram_v1_0 #(
   parameter int WIDTH      = 9,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ipm_distributed_shiftregister_mc_v2_0.sv
// Multi-channel programmable delay line built on a circular buffer.
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   i_aclken    : clock enable; all state and outputs hold when low
//   din         : CHANNELS lanes of DATA_WIDTH bits
//   din_valid   : qualifies din
//   latency     : requested delay in enabled edges (1..MAX_DEPTH)
//   dout        : delayed data (zero while filling)
//   dout_valid  : delayed din_valid, forced low while filling
//   latency_err : one enabled-cycle pulse for a rejected latency request
//
// Fill FSM:
//   state | meaning
//   FILL  | buffer not yet primed for lat_q; dout_valid/dout masked
//   RUN   | dout/dout_valid follow the stored word at wptr - lat_q
import ipm_shiftregister_pkg::*;

module ipm_distributed_shiftregister_mc_v2_0 #(
   parameter  int DATA_WIDTH      = 8,
   parameter  int CHANNELS        = 1,
   parameter  int MAX_DEPTH       = 16,
   parameter  int DEFAULT_LATENCY = 1,
   parameter  int OUT_REG         = 0,
   localparam int ADDR_WIDTH      = calc_addr_width(MAX_DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_aclken,
   input  logic [CHANNELS*DATA_WIDTH-1:0] din,
   input  logic                           din_valid,
   input  logic [ADDR_WIDTH:0]            latency,
   output logic [CHANNELS*DATA_WIDTH-1:0] dout,
   output logic                           dout_valid,
   output logic                           latency_err
);

   localparam int                W       = CHANNELS * DATA_WIDTH;
   localparam logic [ADDR_WIDTH:0] MAX_LAT = (ADDR_WIDTH+1)'(MAX_DEPTH);
   localparam logic [ADDR_WIDTH:0] DEF_LAT = (ADDR_WIDTH+1)'(DEFAULT_LATENCY);

   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [ADDR_WIDTH:0]   lat_q;
   logic [ADDR_WIDTH:0]   fill_cnt;
   fill_state_t           state;
   logic                  lat_bad;
   logic                  lat_new;
   logic [W:0]            rdata;
   logic [W-1:0]          dout_c;
   logic                  dout_valid_c;

   assign lat_bad = (latency == '0) || (latency > MAX_LAT);
   assign lat_new = !lat_bad && (latency != lat_q);

   // lat_q == 2^ADDR_WIDTH truncates to 0 and reads the slot about to be
   // overwritten, which still holds the word from a full wrap ago.
   assign raddr = wptr - lat_q[ADDR_WIDTH-1:0];

   ipm_distributed_ram_v1_0 #(
      .WIDTH      (W + 1),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (i_aclken),
      .waddr (wptr),
      .wdata ({din_valid, din}),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr        <= '0;
         lat_q       <= DEF_LAT;
         fill_cnt    <= '0;
         state       <= FILL;
         latency_err <= 1'b0;
      end else if (i_aclken) begin
         wptr        <= wptr + 1'b1;
         latency_err <= lat_bad;
         if (lat_new) begin
            lat_q    <= latency;
            fill_cnt <= '0;
            state    <= FILL;
         end else if (state == FILL) begin
            if (fill_cnt == lat_q - 1'b1) begin
               state <= RUN;
            end else begin
               fill_cnt <= fill_cnt + 1'b1;
            end
         end
      end
   end

   // Masking by state keeps dout deterministic (zero) while filling and
   // makes reset clear the outputs immediately.
   assign dout_c       = (state == RUN) ? rdata[W-1:0] : '0;
   assign dout_valid_c = (state == RUN) && rdata[W];

   generate
      if (OUT_REG != 0) begin : g_oreg
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               dout       <= '0;
               dout_valid <= 1'b0;
            end else if (i_aclken) begin
               dout       <= dout_c;
               dout_valid <= dout_valid_c;
            end
         end
      end else begin : g_comb
         assign dout       = dout_c;
         assign dout_valid = dout_valid_c;
      end
   endgenerate

endmodule

// File: tb/tb_ipm_distributed_shiftregister_mc_v2_0.sv
module tb_ipm_distributed_shiftregister_mc_v2_0;

   localparam int MD  = 16;
   localparam int DEF = 5;
   localparam int BMD = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        en_s  = 1'b0;
   logic        v_s   = 1'b0;
   logic [15:0] din_s = '0;
   logic [4:0]  lat_s = 5'd5;
   logic [15:0] dout_s;
   logic        dv_s;
   logic        err_s;

   logic        en_b  = 1'b0;
   logic        v_b   = 1'b0;
   logic [15:0] din_b = '0;
   logic [10:0] lat_b = 11'd1024;
   logic [15:0] dout_b;
   logic        dv_b;
   logic        err_b;

   always #5 clk = ~clk;

   ipm_distributed_shiftregister_mc_v2_0 #(
      .DATA_WIDTH(8), .CHANNELS(2), .MAX_DEPTH(MD), .DEFAULT_LATENCY(DEF), .OUT_REG(0)
   ) dut_s (
      .clk(clk), .rst(rst), .i_aclken(en_s), .din(din_s), .din_valid(v_s),
      .latency(lat_s), .dout(dout_s), .dout_valid(dv_s), .latency_err(err_s)
   );

   ipm_distributed_shiftregister_mc_v2_0 #(
      .DATA_WIDTH(16), .CHANNELS(1), .MAX_DEPTH(BMD), .DEFAULT_LATENCY(BMD), .OUT_REG(1)
   ) dut_b (
      .clk(clk), .rst(rst), .i_aclken(en_b), .din(din_b), .din_valid(v_b),
      .latency(lat_b), .dout(dout_b), .dout_valid(dv_b), .latency_err(err_b)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        run;
      logic        v;
      logic        e;
      logic [15:0] d;
   } exp_t;

   exp_t        sb[$];
   logic [16:0] hist[$];
   logic [15:0] hist_b[$];
   int          m_lat   = DEF;
   int          m_since = 0;
   logic        m_err   = 1'b0;
   int          n       = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock on the small instance; the model tracks enabled edges since
   // the last reset / accepted latency change to decide when output is live.
   task automatic step_s(input logic en, input logic vld, input int lat);
      exp_t        x;
      logic [16:0] h;
      din_s = 16'h0100 + 16'(n);
      v_s   = vld;
      en_s  = en;
      lat_s = 5'(lat);
      if (en) begin
         hist.push_back({vld, din_s});
         m_err = (lat == 0) || (lat > MD);
         if (!m_err && lat != m_lat) begin
            m_lat   = lat;
            m_since = 0;
         end else begin
            m_since++;
         end
         n++;
      end
      x.run = (m_since >= m_lat);
      x.e   = m_err;
      h     = x.run ? hist[hist.size() - m_lat] : 17'h0;
      x.v   = x.run && h[16];
      x.d   = h[15:0];
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("dout_valid", 32'(dv_s), 32'(x.v));
      chk("latency_err", 32'(err_s), 32'(x.e));
      if (x.run) chk("dout", 32'(dout_s), 32'(x.d));
   endtask

   initial begin
      exp_t x;
      int   wr;

      #3;
      chk("rst_dout", 32'(dout_s), 32'h0);
      chk("rst_dout_valid", 32'(dv_s), 32'h0);
      chk("rst_latency_err", 32'(err_s), 32'h0);
      chk("rst_big_dout_valid", 32'(dv_b), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // L=5 ramp straight out of reset
      for (int i = 0; i < 12; i++) step_s(1'b1, 1'b1, 5);
      // L=3 with clock enable toggling
      for (int i = 0; i < 16; i++) step_s((i % 2) == 0, 1'b1, 3);
      // L=4 then 9 mid-stream, mixed valid bits, 9 held (no restart)
      for (int i = 0; i < 10; i++) step_s(1'b1, (n % 7) != 6, 4);
      for (int i = 0; i < 20; i++) step_s(1'b1, (n % 7) != 6, 9);
      // rejected latencies
      for (int i = 0; i < 10; i++) step_s(1'b1, 1'b1, 4);
      step_s(1'b1, 1'b1, 0);
      step_s(1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++) step_s(1'b1, 1'b1, 4);
      step_s(1'b1, 1'b1, 17);
      for (int i = 0; i < 3; i++) step_s(1'b1, 1'b1, 4);
      // boundary latencies
      for (int i = 0; i < 24; i++) step_s(1'b1, 1'b1, 16);
      for (int i = 0; i < 4; i++) step_s(1'b1, 1'b1, 1);
      for (int i = 0; i < 8; i++) step_s(1'b1, 1'b1, 5);

      // asynchronous reset between edges while output is live
      chk("pre_rst_valid", 32'(dv_s), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_dout", 32'(dout_s), 32'h0);
      chk("async_rst_dout_valid", 32'(dv_s), 32'h0);
      chk("async_rst_latency_err", 32'(err_s), 32'h0);
      #1;
      rst = 1'b1;
      hist.delete();
      m_lat   = DEF;
      m_since = 0;
      m_err   = 1'b0;
      for (int i = 0; i < 10; i++) step_s(1'b1, 1'b1, 5);
      en_s = 1'b0;

      // big instance: OUT_REG=1, L=1024, wrap-around
      v_b = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         en_b  = (i % 97) != 96;
         din_b = 16'(i * 3 + 7);
         if (en_b) hist_b.push_back(din_b);
         wr    = hist_b.size();
         x.run = (wr - 1 - BMD) >= 0;
         x.v   = x.run;
         x.e   = 1'b0;
         x.d   = x.run ? hist_b[wr - 1 - BMD] : 16'h0;
         sb.push_back(x);
         @(posedge clk);
         #1;
         x = sb.pop_front();
         chk("big_dout_valid", 32'(dv_b), 32'(x.v));
         if (x.run) chk("big_dout", 32'(dout_b), 32'(x.d));
      end
      chk("big_latency_err", 32'(err_b), 32'h0);
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
